// File: rtl/reconf_dispatcher.sv
// reconf_dispatcher: queues reconfiguration commands and applies each committed batch
// atomically, holding the switch input until the batch's last start pulse has been issued.
module reconf_dispatcher #(
  parameter int NUM_PROC = 2,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [NUM_PROC-1:0]     cmd_proc_mask_i,
  input  logic [1:0]              cmd_kind_i,
  input  logic [DATA_W-1:0]       cmd_data_i,
  input  logic                    cmd_commit_i,
  input  logic                    sw_idle_i,
  output logic                    sw_hold_o,
  output logic [4*NUM_PROC-1:0]   mod_start_o,
  output logic [DATA_W-1:0]       mod_data_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  pending_o,
  output logic                    err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [NUM_PROC-1:0] mask_mem_r   [DEPTH];
  logic [1:0]          kind_mem_r   [DEPTH];
  logic [DATA_W-1:0]   data_mem_r   [DEPTH];
  logic                commit_mem_r [DEPTH];

  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;
  logic [CW-1:0]       pending_r;
  logic [CW-1:0]       pending_nxt_s;
  logic                ready_r;
  logic                err_r;
  logic                hold_r;
  logic [4*NUM_PROC-1:0] start_r;
  logic [4*NUM_PROC-1:0] start_s;
  logic [DATA_W-1:0]   data_r;

  logic                push_s;
  logic                pop_s;
  logic                ovf_s;
  logic [NUM_PROC-1:0] head_mask_s;
  logic [1:0]          head_kind_s;
  logic [DATA_W-1:0]   head_data_s;
  logic                head_commit_s;

  assign push_s        = cmd_valid_i & ready_r;
  assign pop_s         = (state_r == ST_ISSUE) && (count_r != {CW{1'b0}});
  // A full FIFO without a commit entry can never complete a batch
  assign ovf_s         = (count_r == DEPTH_C) && (pending_r == {CW{1'b0}});
  assign head_mask_s   = mask_mem_r[rd_ptr_r];
  assign head_kind_s   = kind_mem_r[rd_ptr_r];
  assign head_data_s   = data_mem_r[rd_ptr_r];
  assign head_commit_s = commit_mem_r[rd_ptr_r];

  assign cmd_ready_o = ready_r;
  assign sw_hold_o   = hold_r;
  assign busy_o      = hold_r;
  assign mod_start_o = start_r;
  assign mod_data_o  = data_r;
  assign pending_o   = pending_r;
  assign err_o       = err_r;

  // Next FIFO occupancy and committed-batch count
  always_comb begin
    count_nxt_s   = count_r;
    pending_nxt_s = pending_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
    case ({push_s & cmd_commit_i, pop_s & head_commit_s})
      2'b10:   pending_nxt_s = pending_r + CW'(1'b1);
      2'b01:   pending_nxt_s = pending_r - CW'(1'b1);
      default: pending_nxt_s = pending_r;
    endcase
  end

  // FSM next-state; a commit accepted while idle starts the hold on the next cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_nxt_s != {CW{1'b0}}) state_nxt_s = ST_HOLD;
        else                             state_nxt_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (sw_idle_i) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_HOLD;
      end
      ST_ISSUE: begin
        if (!pop_s || head_commit_s) state_nxt_s = ST_DRAIN;
        else                         state_nxt_s = ST_ISSUE;
      end
      ST_DRAIN: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Decode the popped entry into per-processor, per-module start bits
  always_comb begin
    start_s = {(4*NUM_PROC){1'b0}};
    for (int p = 0; p < NUM_PROC; p++) begin
      for (int k = 0; k < 4; k++) begin
        start_s[p*4+k] = pop_s & head_mask_s[p] & (head_kind_s == 2'(k));
      end
    end
  end

  // FIFO storage, written only on an accepted command
  always_ff @(posedge clk) begin
    if (push_s) begin
      mask_mem_r[wr_ptr_r]   <= cmd_proc_mask_i;
      kind_mem_r[wr_ptr_r]   <= cmd_kind_i;
      data_mem_r[wr_ptr_r]   <= cmd_data_i;
      commit_mem_r[wr_ptr_r] <= cmd_commit_i;
    end
  end

  // Control state, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      pending_r <= {CW{1'b0}};
      ready_r   <= 1'b1;
      err_r     <= 1'b0;
      hold_r    <= 1'b0;
      start_r   <= {(4*NUM_PROC){1'b0}};
      data_r    <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      hold_r    <= (state_nxt_s != ST_IDLE);
      start_r   <= start_s;
      pending_r <= pending_nxt_s;
      if (pop_s) data_r <= head_data_s;
      if (ovf_s) begin
        err_r    <= 1'b1;
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
        ready_r  <= 1'b1;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        count_r <= count_nxt_s;
        ready_r <= (count_nxt_s < DEPTH_C);
      end
    end
  end

endmodule

// File: tb/tb_reconf_dispatcher.sv
// Self-checking bench for reconf_dispatcher: randomized batches checked against
// expectations derived from the batch timing rules (hold window, pulse slots, counts).
module tb_reconf_dispatcher;
  localparam int NP = 2;
  localparam int DW = 16;
  localparam int DP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [NP-1:0]  cmd_proc_mask_i;
  logic [1:0]     cmd_kind_i;
  logic [DW-1:0]  cmd_data_i;
  logic           cmd_commit_i;
  logic           sw_idle_i;
  logic           sw_hold_o;
  logic [4*NP-1:0] mod_start_o;
  logic [DW-1:0]  mod_data_o;
  logic           busy_o;
  logic [$clog2(DP):0] pending_o;
  logic           err_o;

  reconf_dispatcher #(.NUM_PROC(NP), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_proc_mask_i(cmd_proc_mask_i), .cmd_kind_i(cmd_kind_i),
    .cmd_data_i(cmd_data_i), .cmd_commit_i(cmd_commit_i),
    .sw_idle_i(sw_idle_i), .sw_hold_o(sw_hold_o),
    .mod_start_o(mod_start_o), .mod_data_o(mod_data_o),
    .busy_o(busy_o), .pending_o(pending_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_data;
  logic          model_err;
  logic [1:0]    b_mask [8];
  logic [1:0]    b_kind [8];
  logic [DW-1:0] b_data [8];
  int            b_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_cmd();
    cmd_valid_i     = 1'b0;
    cmd_proc_mask_i = 2'b00;
    cmd_kind_i      = 2'd0;
    cmd_data_i      = 16'd0;
    cmd_commit_i    = 1'b0;
  endtask

  // Expected start vector: one bit per selected processor at p*4+kind
  function automatic logic [7:0] exp_vec(input logic [1:0] m, input logic [1:0] k);
    logic [7:0] v;
    v = 8'd0;
    for (int p = 0; p < NP; p++) if (m[p]) v[p*4 + int'(k)] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    no_cmd();
    sw_idle_i = 1'b1;
    tick();
    tick();
    n_tests++; if ({sw_hold_o, busy_o, err_o, cmd_ready_o} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0001", {sw_hold_o, busy_o, err_o, cmd_ready_o});
    end
    n_tests++; if (mod_start_o !== 8'd0) begin
      n_fail++; $display("FAIL reset_start: got %h expected 00", mod_start_o);
    end
    n_tests++; if (mod_data_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", mod_data_o);
    end
    n_tests++; if (pending_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending_o);
    end
    rst = 1'b1;
    model_data = 16'd0;
    model_err  = 1'b0;
    tick();
  endtask

  // Push batch b_* from IDLE, keep sw_idle_i low for d cycles in HOLD, check every cycle
  task automatic test_batch(input int d, input string name);
    int k;
    int hold_cnt;
    int pi;
    logic eh;
    logic [7:0] ev;
    logic [2:0] ep;
    k = b_n;
    hold_cnt = 0;
    sw_idle_i = 1'b1;
    for (int i = 0; i < k; i++) begin
      cmd_valid_i     = 1'b1;
      cmd_proc_mask_i = b_mask[i];
      cmd_kind_i      = b_kind[i];
      cmd_data_i      = b_data[i];
      cmd_commit_i    = (i == k-1);
      n_tests++; if (cmd_ready_o !== 1'b1 || sw_hold_o !== 1'b0 || pending_o !== 3'd0) begin
        n_fail++; $display("FAIL %s_push%0d: got ready=%b hold=%b pending=%0d expected 1 0 0", name, i, cmd_ready_o, sw_hold_o, pending_o);
      end
      tick();
    end
    no_cmd();
    for (int rel = 1; rel <= k + d + 3; rel++) begin
      sw_idle_i = (rel - 1 >= d);
      eh = (rel <= k + d + 2);
      pi = rel - 3 - d;
      ev = 8'd0;
      if (pi >= 0 && pi < k) begin
        ev = exp_vec(b_mask[pi], b_kind[pi]);
        model_data = b_data[pi];
      end
      ep = (rel <= d + k + 1) ? 3'd1 : 3'd0;
      n_tests++; if ({sw_hold_o, busy_o} !== {eh, eh}) begin
        n_fail++; $display("FAIL %s_hold@%0d: got hold=%b busy=%b expected %b", name, rel, sw_hold_o, busy_o, eh);
      end
      n_tests++; if (mod_start_o !== ev) begin
        n_fail++; $display("FAIL %s_start@%0d: got %b expected %b", name, rel, mod_start_o, ev);
      end
      n_tests++; if (mod_data_o !== model_data) begin
        n_fail++; $display("FAIL %s_data@%0d: got %h expected %h", name, rel, mod_data_o, model_data);
      end
      n_tests++; if (pending_o !== ep || err_o !== model_err) begin
        n_fail++; $display("FAIL %s_cnt@%0d: got pending=%0d err=%b expected %0d %b", name, rel, pending_o, err_o, ep, model_err);
      end
      if (sw_hold_o) hold_cnt++;
      tick();
    end
    n_tests++; if (hold_cnt != k + 2 + d) begin
      n_fail++; $display("FAIL %s_hold_len: got %0d expected %0d", name, hold_cnt, k + 2 + d);
    end
  endtask

  task automatic test_single_broadcast();
    b_n = 3;
    for (int i = 0; i < 3; i++) begin
      b_mask[i] = 2'b11;
      b_data[i] = 16'(i + 1);
    end
    b_kind[0] = 2'd0; b_kind[1] = 2'd1; b_kind[2] = 2'd3;
    test_batch(0, "broadcast");
  endtask

  task automatic test_targeting();
    b_n = 2;
    b_mask[0] = 2'b01; b_mask[1] = 2'b10;
    b_kind[0] = 2'd2;  b_kind[1] = 2'd2;
    b_data[0] = 16'($urandom); b_data[1] = 16'($urandom);
    test_batch(0, "target");
  endtask

  task automatic test_drain_wait();
    b_n = 2;
    for (int i = 0; i < 2; i++) begin
      b_mask[i] = 2'($urandom_range(1, 3));
      b_kind[i] = 2'($urandom_range(0, 3));
      b_data[i] = 16'($urandom);
    end
    test_batch(5, "drain_wait");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      b_n = $urandom_range(1, DP);
      for (int i = 0; i < b_n; i++) begin
        b_mask[i] = 2'($urandom_range(0, 3));
        b_kind[i] = 2'($urandom_range(0, 3));
        b_data[i] = 16'($urandom);
      end
      test_batch($urandom_range(0, 3), "random");
    end
  endtask

  // Two 2-entry batches pushed on cycles 0..3 with the switch always idle
  task automatic test_back_to_back();
    logic [2:0] ep [13];
    logic [7:0] ev;
    logic eh;
    int pi;
    int pulses;
    ep = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      b_mask[i] = 2'($urandom_range(1, 3));
      b_kind[i] = 2'($urandom_range(0, 3));
      b_data[i] = 16'($urandom);
    end
    sw_idle_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      eh = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
      pi = (c == 4) ? 0 : (c == 5) ? 1 : (c == 9) ? 2 : (c == 10) ? 3 : -1;
      ev = 8'd0;
      if (pi >= 0) begin
        ev = exp_vec(b_mask[pi], b_kind[pi]);
        model_data = b_data[pi];
      end
      n_tests++; if (sw_hold_o !== eh) begin
        n_fail++; $display("FAIL b2b_hold@%0d: got %b expected %b", c, sw_hold_o, eh);
      end
      n_tests++; if (mod_start_o !== ev || mod_data_o !== model_data) begin
        n_fail++; $display("FAIL b2b_pulse@%0d: got %b/%h expected %b/%h", c, mod_start_o, mod_data_o, ev, model_data);
      end
      n_tests++; if (pending_o !== ep[c]) begin
        n_fail++; $display("FAIL b2b_pending@%0d: got %0d expected %0d", c, pending_o, ep[c]);
      end
      if (mod_start_o != 8'd0) pulses++;
      if (c < 4) begin
        cmd_valid_i     = 1'b1;
        cmd_proc_mask_i = b_mask[c];
        cmd_kind_i      = b_kind[c];
        cmd_data_i      = b_data[c];
        cmd_commit_i    = (c == 1 || c == 3);
      end else begin
        no_cmd();
      end
      tick();
    end
    n_tests++; if (pulses != 4) begin
      n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 4", pulses);
    end
  endtask

  task automatic test_overflow();
    sw_idle_i = 1'b1;
    for (int i = 0; i < DP; i++) begin
      cmd_valid_i     = 1'b1;
      cmd_proc_mask_i = 2'($urandom_range(0, 3));
      cmd_kind_i      = 2'($urandom_range(0, 3));
      cmd_data_i      = 16'($urandom);
      cmd_commit_i    = 1'b0;
      n_tests++; if (cmd_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL ovf_fill%0d: got ready=%b expected 1", i, cmd_ready_o);
      end
      tick();
    end
    n_tests++; if (cmd_ready_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full: got ready=%b err=%b expected 0 0", cmd_ready_o, err_o);
    end
    cmd_commit_i = 1'b1;
    tick();
    no_cmd();
    model_err = 1'b1;
    n_tests++; if (err_o !== 1'b1 || cmd_ready_o !== 1'b1 || pending_o !== 3'd0 || sw_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_flush: got err=%b ready=%b pending=%0d hold=%b expected 1 1 0 0", err_o, cmd_ready_o, pending_o, sw_hold_o);
    end
    tick();
    n_tests++; if (sw_hold_o !== 1'b0 || mod_start_o !== 8'd0) begin
      n_fail++; $display("FAIL ovf_idle: got hold=%b start=%b expected 0 0", sw_hold_o, mod_start_o);
    end
    b_n = 1;
    b_mask[0] = 2'($urandom_range(1, 3));
    b_kind[0] = 2'($urandom_range(0, 3));
    b_data[0] = 16'($urandom);
    test_batch(0, "ovf_batch");
  endtask

  task automatic test_reset_mid_issue();
    sw_idle_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_mask[i] = 2'b11;
      b_kind[i] = 2'($urandom_range(0, 3));
      b_data[i] = 16'($urandom);
      cmd_valid_i     = 1'b1;
      cmd_proc_mask_i = b_mask[i];
      cmd_kind_i      = b_kind[i];
      cmd_data_i      = b_data[i];
      cmd_commit_i    = (i == 2);
      tick();
    end
    no_cmd();
    tick();
    tick();
    n_tests++; if (mod_start_o !== exp_vec(b_mask[0], b_kind[0]) || mod_data_o !== b_data[0]) begin
      n_fail++; $display("FAIL rmi_first_pulse: got %b/%h expected %b/%h", mod_start_o, mod_data_o, exp_vec(b_mask[0], b_kind[0]), b_data[0]);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_data = 16'd0;
    model_err  = 1'b0;
    n_tests++; if ({sw_hold_o, busy_o, err_o, cmd_ready_o} !== 4'b0001 || pending_o !== 3'd0) begin
      n_fail++; $display("FAIL rmi_flags: got %b pending=%0d expected 0001 0", {sw_hold_o, busy_o, err_o, cmd_ready_o}, pending_o);
    end
    n_tests++; if (mod_start_o !== 8'd0 || mod_data_o !== 16'd0) begin
      n_fail++; $display("FAIL rmi_outputs: got %b/%h expected 0/0", mod_start_o, mod_data_o);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++; if (mod_start_o !== 8'd0 || sw_hold_o !== 1'b0) begin
        n_fail++; $display("FAIL rmi_quiet@%0d: got start=%b hold=%b expected 0 0", c, mod_start_o, sw_hold_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_broadcast();
    test_targeting();
    test_drain_wait();
    test_random();
    test_back_to_back();
    test_overflow();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
